// File: rtl/oled_init_seq_if.sv
// Byte handshake between the OLED init sequencer and the SPI byte writer.
// The sequencer drives each byte with its DC flag and is told when the byte has been shifted out.
interface oled_init_seq_if;
    logic       ena_write;
    logic [7:0] data;
    logic       oled_dc;
    logic       write_done;

    modport master (
        output ena_write,
        output data,
        output oled_dc,
        input  write_done
    );

    modport slave (
        input  ena_write,
        input  data,
        input  oled_dc,
        output write_done
    );
endinterface

// File: rtl/oled_init_seq.sv
// SSD1306 bring-up sequencer: pulses the panel reset, streams the init command list,
// then writes every page with a pattern byte, one byte per writer handshake.
module oled_init_seq #(
    parameter int RST_LOW_CYCLES  = 1000,
    parameter int RST_WAIT_CYCLES = 1000,
    parameter int PAGES           = 8,
    parameter int COLS            = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      fill,
    oled_init_seq_if.master wr,
    output logic            oled_cs,
    output logic            oled_res,
    output logic            busy,
    output logic            init_done
);

    localparam int CNT_MAX  = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int PW       = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int LW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int INIT_LEN = 28;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RST_LOW  = 3'd1;
    localparam logic [2:0] S_RST_WAIT = 3'd2;
    localparam logic [2:0] S_LOAD     = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_FINISH   = 3'd5;

    localparam logic [1:0] PH_INIT = 2'd0;
    localparam logic [1:0] PH_CMD  = 2'd1;
    localparam logic [1:0] PH_DATA = 2'd2;

    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        case (idx)
            5'd0:  return 8'hAE;  5'd1:  return 8'h00;  5'd2:  return 8'h10;  5'd3:  return 8'h40;
            5'd4:  return 8'h81;  5'd5:  return 8'hCF;  5'd6:  return 8'hA1;  5'd7:  return 8'hC8;
            5'd8:  return 8'hA6;  5'd9:  return 8'hA8;  5'd10: return 8'h3F;  5'd11: return 8'hD3;
            5'd12: return 8'h00;  5'd13: return 8'hD5;  5'd14: return 8'h80;  5'd15: return 8'hD9;
            5'd16: return 8'hF1;  5'd17: return 8'hDA;  5'd18: return 8'h12;  5'd19: return 8'hDB;
            5'd20: return 8'h40;  5'd21: return 8'h20;  5'd22: return 8'h02;  5'd23: return 8'h8D;
            5'd24: return 8'h14;  5'd25: return 8'hA4;  5'd26: return 8'hA6;  5'd27: return 8'hAF;
            default: return 8'h00;
        endcase
    endfunction

    logic [2:0]    state_reg;
    logic [CW-1:0] cyc_reg;
    logic [7:0]    fill_reg;
    logic          cs_reg, res_reg, busy_reg, done_reg;

    logic [1:0]    phase_reg, phase_next;
    logic [4:0]    init_reg, init_next;
    logic [PW-1:0] page_reg, page_next;
    logic [LW-1:0] col_reg, col_next;
    logic [1:0]    sub_reg, sub_next;

    logic          ena_reg, dc_reg, last_reg;
    logic [7:0]    data_reg;

    logic [7:0]    page_b;
    logic [7:0]    cur_byte;
    logic          cur_dc, cur_last;
    logic          start_acc, low_end, wait_end, load_en, finish_en;

    assign start_acc = (state_reg == S_IDLE) && start;
    assign low_end   = (state_reg == S_RST_LOW)  && (cyc_reg == CW'(RST_LOW_CYCLES - 1));
    assign wait_end  = (state_reg == S_RST_WAIT) && (cyc_reg == CW'(RST_WAIT_CYCLES - 1));
    // A byte is loaded either as the very first one or right after the writer finishes the previous one.
    assign load_en   = wait_end || ((state_reg == S_WAIT) && wr.write_done && !last_reg);
    assign finish_en = (state_reg == S_WAIT) && wr.write_done && last_reg;

    assign page_b = 8'(page_reg);

    // Byte selected by the step counters, and the step that follows it.
    always_comb begin
        cur_byte   = 8'h00;
        cur_dc     = 1'b0;
        cur_last   = 1'b0;
        phase_next = phase_reg;
        init_next  = init_reg;
        page_next  = page_reg;
        col_next   = col_reg;
        sub_next   = sub_reg;
        case (phase_reg)
            PH_INIT: begin
                cur_byte = init_rom(init_reg);
                if (init_reg == 5'(INIT_LEN - 1)) begin
                    phase_next = PH_CMD;
                    page_next  = '0;
                    sub_next   = 2'd0;
                end else begin
                    init_next = init_reg + 5'd1;
                end
            end
            PH_CMD: begin
                case (sub_reg)
                    2'd0:    cur_byte = 8'hB0 | (page_b & 8'h07);
                    2'd1:    cur_byte = 8'h00;
                    default: cur_byte = 8'h10;
                endcase
                if (sub_reg == 2'd2) begin
                    phase_next = PH_DATA;
                    col_next   = '0;
                end else begin
                    sub_next = sub_reg + 2'd1;
                end
            end
            PH_DATA: begin
                cur_byte = fill_reg;
                cur_dc   = 1'b1;
                if (col_reg == LW'(COLS - 1)) begin
                    if (page_reg == PW'(PAGES - 1)) begin
                        cur_last = 1'b1;
                    end else begin
                        page_next  = page_reg + PW'(1);
                        sub_next   = 2'd0;
                        phase_next = PH_CMD;
                    end
                end else begin
                    col_next = col_reg + LW'(1);
                end
            end
            default: phase_next = PH_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cyc_reg   <= '0;
            fill_reg  <= 8'h00;
            cs_reg    <= 1'b1;
            res_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        fill_reg  <= fill;
                        done_reg  <= 1'b0;
                        busy_reg  <= 1'b1;
                        res_reg   <= 1'b0;
                        cyc_reg   <= '0;
                        state_reg <= S_RST_LOW;
                    end
                end
                S_RST_LOW: begin
                    if (low_end) begin
                        res_reg   <= 1'b1;
                        cyc_reg   <= '0;
                        state_reg <= S_RST_WAIT;
                    end else begin
                        cyc_reg <= cyc_reg + CW'(1);
                    end
                end
                S_RST_WAIT: begin
                    if (wait_end) begin
                        cs_reg    <= 1'b0;
                        state_reg <= S_LOAD;
                    end else begin
                        cyc_reg <= cyc_reg + CW'(1);
                    end
                end
                S_LOAD: state_reg <= S_WAIT;
                S_WAIT: begin
                    if (finish_en) begin
                        cs_reg    <= 1'b1;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_FINISH;
                    end else if (wr.write_done) begin
                        state_reg <= S_LOAD;
                    end
                end
                S_FINISH: state_reg <= S_IDLE;
                default:  state_reg <= S_IDLE;
            endcase
        end
    end

    // Byte/DC registers only move when a byte is loaded, so they stay put while the writer shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena_reg   <= 1'b0;
            data_reg  <= 8'h00;
            dc_reg    <= 1'b0;
            last_reg  <= 1'b0;
            phase_reg <= PH_INIT;
            init_reg  <= '0;
            page_reg  <= '0;
            col_reg   <= '0;
            sub_reg   <= '0;
        end else begin
            ena_reg <= load_en;
            if (start_acc) begin
                last_reg  <= 1'b0;
                phase_reg <= PH_INIT;
                init_reg  <= '0;
                page_reg  <= '0;
                col_reg   <= '0;
                sub_reg   <= '0;
            end else if (load_en) begin
                data_reg  <= cur_byte;
                dc_reg    <= cur_dc;
                last_reg  <= cur_last;
                phase_reg <= phase_next;
                init_reg  <= init_next;
                page_reg  <= page_next;
                col_reg   <= col_next;
                sub_reg   <= sub_next;
            end
        end
    end

    assign wr.ena_write = ena_reg;
    assign wr.data      = data_reg;
    assign wr.oled_dc   = dc_reg;
    assign oled_cs      = cs_reg;
    assign oled_res     = res_reg;
    assign busy         = busy_reg;
    assign init_done    = done_reg;

endmodule

// File: tb/tb_oled_init_seq.sv
// Bench for oled_init_seq: behavioural SPI writer answering 18 cycles after each request,
// byte capture with handshake checks, and directed sequences compared against a byte-stream model.
module tb_oled_init_seq;

    localparam int LOWC  = 4;
    localparam int WAITC = 3;
    localparam int PAGES = 8;
    localparam int COLS  = 128;
    localparam int TOTAL = 28 + PAGES * (3 + COLS);
    localparam int CAPN  = 4096;
    localparam logic [7:0] ROM [28] = '{
        8'hAE, 8'h00, 8'h10, 8'h40, 8'h81, 8'hCF, 8'hA1, 8'hC8, 8'hA6, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'hD5,
        8'h80, 8'hD9, 8'hF1, 8'hDA, 8'h12, 8'hDB, 8'h40, 8'h20, 8'h02, 8'h8D, 8'h14, 8'hA4, 8'hA6, 8'hAF};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] fill = 8'h00;
    logic       oled_cs, oled_res, busy, init_done;
    logic       wd_model = 1'b0;
    logic       spur_done = 1'b0;

    oled_init_seq_if bus ();
    assign bus.write_done = wd_model | spur_done;

    oled_init_seq #(
        .RST_LOW_CYCLES (LOWC),
        .RST_WAIT_CYCLES(WAITC),
        .PAGES          (PAGES),
        .COLS           (COLS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .fill     (fill),
        .wr       (bus),
        .oled_cs  (oled_cs),
        .oled_res (oled_res),
        .busy     (busy),
        .init_done(init_done)
    );

    initial forever #5 clk = ~clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Writer model and capture, sampled mid-cycle.
    logic [7:0] cap_data [CAPN];
    logic       cap_dc   [CAPN];
    int         n_ena = 0, pend = 0, cyc = 0;
    int         viol_consec = 0, viol_outst = 0, viol_hold = 0;
    int         last_done_cyc = 0, fin_cyc = 0, fin_cnt = 0;
    logic       outst = 1'b0, prev_ena = 1'b0, prev_id = 1'b0;
    logic [7:0] held_d = 8'h00;
    logic       held_dc = 1'b0;
    logic       fin_cs = 1'b0, fin_busy = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            wd_model = 1'b0;
            outst    = 1'b0;
            pend     = 0;
            prev_ena = 1'b0;
            prev_id  = 1'b0;
        end else begin
            if (wd_model) begin
                wd_model = 1'b0;
                outst    = 1'b0;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    wd_model      = 1'b1;
                    last_done_cyc = cyc;
                end
            end
            if (bus.ena_write) begin
                if (prev_ena) viol_consec++;
                if (outst) viol_outst++;
                if (n_ena < CAPN) begin
                    cap_data[n_ena] = bus.data;
                    cap_dc[n_ena]   = bus.oled_dc;
                end
                n_ena++;
                outst   = 1'b1;
                held_d  = bus.data;
                held_dc = bus.oled_dc;
                pend    = 18;
            end else if (outst && (bus.data !== held_d || bus.oled_dc !== held_dc)) begin
                viol_hold++;
            end
            if (init_done && !prev_id) begin
                fin_cyc  = cyc;
                fin_cs   = oled_cs;
                fin_busy = busy;
                fin_cnt++;
            end
            prev_ena = bus.ena_write;
            prev_id  = init_done;
        end
    end

    function automatic logic [8:0] exp_word(input int i, input logic [7:0] f);
        int r, p, k;
        if (i < 28) return {1'b0, ROM[i]};
        r = i - 28;
        p = r / (3 + COLS);
        k = r % (3 + COLS);
        if (k == 0) return {1'b0, 8'hB0 | 8'(p)};
        if (k == 1) return {1'b0, 8'h00};
        if (k == 2) return {1'b0, 8'h10};
        return {1'b1, f};
    endfunction

    function automatic int stream_miss(input int base, input int len, input logic [7:0] f);
        int m = 0;
        for (int i = 0; i < len; i++) begin
            if ({cap_dc[base + i], cap_data[base + i]} !== exp_word(i, f)) m++;
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] f);
        tick();
        fill  = f;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ena"},  32'(bus.ena_write), 32'd0);
        check({tag, "_data"}, 32'(bus.data),      32'h00);
        check({tag, "_dc"},   32'(bus.oled_dc),   32'd0);
        check({tag, "_cs"},   32'(oled_cs),       32'd1);
        check({tag, "_res"},  32'(oled_res),      32'd1);
        check({tag, "_busy"}, 32'(busy),          32'd0);
        check({tag, "_done"}, 32'(init_done),     32'd0);
    endtask

    // Start a sequence, measure the reset pulse, optionally inject a stray write_done in RST_WAIT.
    task automatic reset_pulse(input logic [7:0] f, input bit spur, input string tag);
        int low, high;
        do_start(f);
        check({tag, "_busy_on"}, 32'(busy),      32'd1);
        check({tag, "_done_clr"}, 32'(init_done), 32'd0);
        low = 0;
        while (oled_res === 1'b0 && low < 100) begin
            low++;
            tick();
        end
        check({tag, "_res_low"}, 32'(low), 32'(LOWC));
        high = 0;
        while (bus.ena_write !== 1'b1 && high < 100) begin
            if (spur) spur_done = (high == 1);
            high++;
            tick();
        end
        spur_done = 1'b0;
        check({tag, "_res_wait"}, 32'(high), 32'(WAITC));
        check({tag, "_first_data"}, 32'(bus.data), 32'hAE);
        check({tag, "_first_dc"}, 32'(bus.oled_dc), 32'd0);
        check({tag, "_first_cs"}, 32'(oled_cs), 32'd0);
    endtask

    task automatic wait_writes(input int target, input string tag);
        int t = 0;
        while (n_ena < target && t < 30000) begin
            tick();
            t++;
        end
        check({tag, "_reached"}, 32'(n_ena >= target), 32'd1);
    endtask

    task automatic wait_finish(input int fb, input string tag);
        int t = 0;
        while (fin_cnt <= fb && t < 40000) begin
            tick();
            t++;
        end
        check({tag, "_finished"}, 32'(fin_cnt > fb), 32'd1);
    endtask

    initial begin
        int base, fb, n;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // Reset pulse timing, then abort with reset after the first byte
        reset_pulse(8'h00, 1'b0, "A");
        rst = 1'b1;
        #1;
        check_reset_outputs("A_abort");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Full sequence, stray write_done in RST_WAIT, ignored start at write 100
        base = n_ena;
        fb   = fin_cnt;
        reset_pulse(8'hA5, 1'b1, "B");
        wait_writes(base + 100, "B_w100");
        do_start(8'hFF);
        check("B_busy_start_ignored", 32'(busy), 32'd1);
        check("B_res_start_ignored", 32'(oled_res), 32'd1);
        wait_finish(fb, "B");
        tick();
        check("B_count", 32'(n_ena - base), 32'(TOTAL));
        check("B_init_rom_miss", 32'(stream_miss(base, 28, 8'hA5)), 32'd0);
        check("B_pg3_cmd0", {23'd0, cap_dc[base + 421], cap_data[base + 421]}, 32'h0B3);
        check("B_pg3_cmd1", {23'd0, cap_dc[base + 422], cap_data[base + 422]}, 32'h000);
        check("B_pg3_cmd2", {23'd0, cap_dc[base + 423], cap_data[base + 423]}, 32'h010);
        n = 0;
        for (int i = 0; i < COLS; i++) begin
            if (cap_data[base + 424 + i] === 8'hA5 && cap_dc[base + 424 + i] === 1'b1) n++;
        end
        check("B_pg3_data", 32'(n), 32'(COLS));
        check("B_stream_miss", 32'(stream_miss(base, TOTAL, 8'hA5)), 32'd0);
        check("B_fin_latency", 32'(fin_cyc - last_done_cyc), 32'd1);
        check("B_fin_cs", 32'(fin_cs), 32'd1);
        check("B_fin_busy", 32'(fin_busy), 32'd0);
        check("B_init_done", 32'(init_done), 32'd1);
        check("B_cs_idle", 32'(oled_cs), 32'd1);

        // Rerun after completion, then asynchronous reset at write 500
        base = n_ena;
        reset_pulse(8'h3C, 1'b0, "C");
        wait_writes(base + 500, "C_w500");
        rst = 1'b1;
        #1;
        check_reset_outputs("C_abort");
        check("C_stream_miss", 32'(stream_miss(base, 500, 8'h3C)), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Fresh full sequence after the abort
        base = n_ena;
        fb   = fin_cnt;
        reset_pulse(8'h5A, 1'b0, "D");
        wait_finish(fb, "D");
        tick();
        check("D_count", 32'(n_ena - base), 32'(TOTAL));
        check("D_stream_miss", 32'(stream_miss(base, TOTAL, 8'h5A)), 32'd0);
        check("D_init_done", 32'(init_done), 32'd1);

        check("ena_back_to_back", 32'(viol_consec), 32'd0);
        check("ena_outstanding", 32'(viol_outst), 32'd0);
        check("data_dc_hold", 32'(viol_hold), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/oled_init_seq.md
Name: oled_init_seq

Overview:
- Command/data sequencer that sits directly upstream of the SPI byte writer in the OLED path.
- On start, it pulses the OLED hardware reset.
- It then streams a fixed SSD1306 initialisation command list, then clears or fills all 8 pages × 128 columns with a pattern byte.
- Each byte is handed to the writer over an ena_write/data/write_done handshake.
- It also drives the OLED DC, CS and RES pins and reports busy/init_done to the display controller above it.

Parameters:
- RST_LOW_CYCLES, 1000, clk cycles oled_res is held low (1 ms at 1 MHz); minimum 1.
- RST_WAIT_CYCLES, 1000, clk cycles waited after oled_res rises before the first byte; minimum 1.
- PAGES, 8, number of display pages written in the fill phase.
- COLS, 128, data bytes per page.

Ports:
- clk  in  1  system clock, 1 MHz, shared with the SPI writer
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle request to run the full reset/init/fill sequence
- fill  in  8  pattern byte for the fill phase; sampled on the accepted start
- write_done  in  1  one-cycle pulse from the SPI writer: current byte finished
- ena_write  out  1  one-cycle request to the SPI writer
- data  out  8  byte to the SPI writer; held stable from the ena_write cycle until the write_done cycle
- oled_dc  out  1  0 = command, 1 = display data; held stable with data
- oled_cs  out  1  OLED chip select, active-low
- oled_res  out  1  OLED hardware reset, active-low
- busy  out  1  high while the sequence runs
- init_done  out  1  high after a sequence completes; cleared by the next accepted start

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; all counters 0.
  - ena_write=0, data=0x00, oled_dc=0, oled_cs=1, oled_res=1, busy=0, init_done=0.
  - Reset mid-sequence aborts immediately with these values; no partial byte is completed.
- Init ROM, 28 bytes, sent in order with dc=0:
  - AE 00 10 40 81 CF A1 C8 A6 A8 3F D3 00 D5 80 D9 F1 DA 12 DB 40 20 02 8D 14 A4 A6 AF
- Fill phase, for page p = 0..PAGES-1:
  - Commands B0+p, 00, 10 with dc=0.
  - Then COLS bytes of the latched fill value with dc=1.
- Total writes per sequence = 28 + PAGES*(3+COLS); 1076 with defaults.
- States:
  - IDLE: busy=0. start=1 → latch fill, clear init_done, set busy=1 → RST_LOW.
  - RST_LOW: oled_res=0 for exactly RST_LOW_CYCLES cycles → RST_WAIT.
  - RST_WAIT: oled_res=1, wait RST_WAIT_CYCLES cycles → LOAD. oled_cs goes low on entry to the first LOAD.
  - LOAD (1 cycle):
    - drive data/oled_dc for the current step index; ena_write=1 → WAIT.
  - WAIT:
    - ena_write=0; data/dc held.
    - On write_done=1: if the last byte → FINISH, else advance step → LOAD on the next cycle.
    - The single LOAD cycle after write_done aligns with the writer's return to idle.
  - FINISH (1 cycle): oled_cs=1, busy=0, init_done=1 → IDLE.
- Step index:
  - Phase select: INIT, PAGE_CMD, PAGE_DATA.
  - Counters: init index 0..27, page counter 0..PAGES-1, column counter 0..COLS-1, sub-command 0..2.
  - Wrap order: column reaches COLS-1 → page+1, sub-command=0; page PAGES-1 with column COLS-1 → last byte.
  - Page command byte = 8'hB0 | p[2:0].
- Handshake and boundary rules:
  - ena_write is never high for two consecutive cycles.
  - ena_write is never asserted while a byte is outstanding.
  - write_done outside WAIT is ignored.
  - start while busy=1 is ignored; fill is not re-latched.
  - start in the same cycle as FINISH is ignored.
  - start after completion reruns the entire sequence, including the hardware reset pulse.
  - oled_dc changes only in LOAD cycles.

Test Plan:
- Bench setup: behavioural writer model returns write_done 18 cycles after each ena_write. All scenarios use RST_LOW_CYCLES=4, RST_WAIT_CYCLES=3 unless stated.
- Reset check: rst=1 for 3 cycles → ena_write=0, oled_cs=1, oled_res=1, busy=0, init_done=0, data=0x00.
- Reset pulse: start pulse with fill=0x00 → oled_res low for exactly 4 cycles, high 3 cycles, then first ena_write with data=0xAE, dc=0, oled_cs=0.
- Full sequence with defaults, fill=0xA5 → exactly 1076 ena_write pulses. Required contents:
  - first 28 bytes match the init ROM with dc=0;
  - page 3 starts with B3,00,10 (dc=0), followed by 128 bytes of 0xA5 (dc=1);
  - init_done=1 and oled_cs=1 one cycle after the last write_done.
- Handshake: data/dc never change between an ena_write and its write_done. A spurious write_done injected during RST_WAIT → no step advance; the first byte is still 0xAE.
- Start during busy: start with fill=0xFF at write 100 → ignored; all data-phase bytes stay 0xA5; total is still 1076.
- Async reset mid-sequence: rst at write 500 → outputs take reset values immediately. A fresh start then produces the full 1076-write sequence from 0xAE.
